// File: rtl/bp_update_arbiter.sv
// Two-core branch-update FIFOs drained round-robin into the predictor write port,
// with a sweep sequencer clearing all table entries. Option macro: BP_ARB_STATS_EN.
module bp_update_arbiter #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 12,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             c0_upd_valid,
  output logic             c0_upd_ready,
  input  logic [PC_W-1:0]  c0_upd_pc,
  input  logic [PC_W-1:0]  c0_upd_target,
  input  logic             c0_upd_taken,
  input  logic             c1_upd_valid,
  output logic             c1_upd_ready,
  input  logic [PC_W-1:0]  c1_upd_pc,
  input  logic [PC_W-1:0]  c1_upd_target,
  input  logic             c1_upd_taken,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             tbl_wr_en,
  output logic             tbl_wr_clear,
  output logic [IDX_W-1:0] tbl_wr_idx,
  output logic [PC_W-1:0]  tbl_wr_pc,
  output logic [PC_W-1:0]  tbl_wr_target,
  output logic             tbl_wr_taken,
  output logic             tbl_wr_src
`ifdef BP_ARB_STATS_EN
  ,
  output logic [15:0]      c0_stall_cnt,
  output logic [15:0]      c1_stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_CLEAR
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tgt;
    logic            tk;
  } ent_t;

  state_e             state_q;
  logic [IDX_W-1:0]   swp_q;
  logic               rr_q;
  logic               wr_en_q;
  logic               wr_clr_q;
  logic [IDX_W-1:0]   wr_idx_q;
  logic [PC_W-1:0]    wr_pc_q;
  logic [PC_W-1:0]    wr_tgt_q;
  logic               wr_tk_q;
  logic               wr_src_q;

  ent_t               mem_q [2][DEPTH];
  logic [1:0][PW-1:0] wp_q;
  logic [1:0][PW-1:0] rp_q;
  logic [1:0][PW:0]   cnt_q;

  ent_t               din [2];
  ent_t               head;
  logic [1:0]         vld;
  logic [1:0]         rdy;
  logic [1:0]         ne;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic               run;
  logic               gnt_v;
  logic               gnt_s;

  assign din[0] = {c0_upd_pc, c0_upd_target, c0_upd_taken};
  assign din[1] = {c1_upd_pc, c1_upd_target, c1_upd_taken};
  assign vld    = {c1_upd_valid, c0_upd_valid};
  assign rdy[0] = cnt_q[0] < FULL;
  assign rdy[1] = cnt_q[1] < FULL;
  assign ne[0]  = cnt_q[0] != '0;
  assign ne[1]  = cnt_q[1] != '0;
  assign push   = vld & rdy;

  assign run   = state_q == S_RUN;
  assign gnt_v = run && (|ne);
  assign gnt_s = (&ne) ? rr_q : ne[1];
  assign pop   = !gnt_v ? 2'b00 : (gnt_s ? 2'b10 : 2'b01);
  assign head  = mem_q[gnt_s][rp_q[gnt_s]];

  assign c0_upd_ready = rdy[0];
  assign c1_upd_ready = rdy[1];

  // Sweep keeps busy up through the cycle its last clear write is visible.
  assign clear_busy = (state_q != S_RUN) | (wr_en_q & wr_clr_q);

  assign tbl_wr_en     = wr_en_q;
  assign tbl_wr_clear  = wr_clr_q;
  assign tbl_wr_idx    = wr_idx_q;
  assign tbl_wr_pc     = wr_pc_q;
  assign tbl_wr_target = wr_tgt_q;
  assign tbl_wr_taken  = wr_tk_q;
  assign tbl_wr_src    = wr_src_q;

  // FIFO storage; contents need no reset since counts gate every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wp_q[c]] <= din[c];
    end
  end

  // FIFO pointers and occupancy per core.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wp_q[c] <= wp_q[c] + 1'b1;
        if (pop[c])  rp_q[c] <= rp_q[c] + 1'b1;
        if (push[c] && !pop[c]) begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end else if (!push[c] && pop[c]) begin
          cnt_q[c] <= cnt_q[c] - 1'b1;
        end
      end
    end
  end

  // Sweep/run FSM with registered table write port and RR pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_INIT;
      swp_q    <= '0;
      rr_q     <= 1'b0;
      wr_en_q  <= 1'b0;
      wr_clr_q <= 1'b0;
      wr_idx_q <= '0;
      wr_pc_q  <= '0;
      wr_tgt_q <= '0;
      wr_tk_q  <= 1'b0;
      wr_src_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT, S_CLEAR: begin
          wr_en_q  <= 1'b1;
          wr_clr_q <= 1'b1;
          wr_idx_q <= swp_q;
          wr_pc_q  <= '0;
          wr_tgt_q <= '0;
          wr_tk_q  <= 1'b0;
          wr_src_q <= 1'b0;
          swp_q    <= swp_q + 1'b1;
          if (&swp_q) state_q <= S_RUN;
        end
        S_RUN: begin
          wr_en_q  <= gnt_v;
          wr_clr_q <= 1'b0;
          if (gnt_v) begin
            wr_idx_q <= head.pc[IDX_W-1:0];
            wr_pc_q  <= head.pc;
            wr_tgt_q <= head.tgt;
            wr_tk_q  <= head.tk;
            wr_src_q <= gnt_s;
            rr_q     <= ~gnt_s;
          end
          if (clear_req) state_q <= S_CLEAR;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

`ifdef BP_ARB_STATS_EN
  logic [1:0][15:0] stall_q;

  // Saturating per-core stall counters, zeroed by an accepted clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (run && clear_req) begin
      stall_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (vld[c] && !rdy[c] && stall_q[c] != 16'hFFFF) begin
          stall_q[c] <= stall_q[c] + 16'd1;
        end
      end
    end
  end

  assign c0_stall_cnt = stall_q[0];
  assign c1_stall_cnt = stall_q[1];
`endif

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Scoreboard bench for bp_update_arbiter: queue-based reference model,
// randomized traffic plus directed INIT/CLEAR/reset scenarios.
module tb_bp_update_arbiter;

  localparam int DEPTH = 4;
  localparam int IDX_W = 4;
  localparam int PC_W  = 32;
  localparam int NIDX  = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             c0_upd_valid = 1'b0;
  logic             c0_upd_ready;
  logic [PC_W-1:0]  c0_upd_pc = '0;
  logic [PC_W-1:0]  c0_upd_target = '0;
  logic             c0_upd_taken = 1'b0;
  logic             c1_upd_valid = 1'b0;
  logic             c1_upd_ready;
  logic [PC_W-1:0]  c1_upd_pc = '0;
  logic [PC_W-1:0]  c1_upd_target = '0;
  logic             c1_upd_taken = 1'b0;
  logic             clear_req = 1'b0;
  logic             clear_busy;
  logic             tbl_wr_en;
  logic             tbl_wr_clear;
  logic [IDX_W-1:0] tbl_wr_idx;
  logic [PC_W-1:0]  tbl_wr_pc;
  logic [PC_W-1:0]  tbl_wr_target;
  logic             tbl_wr_taken;
  logic             tbl_wr_src;
  logic [15:0]      c0_stall_cnt;
  logic [15:0]      c1_stall_cnt;

  bp_update_arbiter #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W),
    .PC_W (PC_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .c0_upd_valid (c0_upd_valid),
    .c0_upd_ready (c0_upd_ready),
    .c0_upd_pc    (c0_upd_pc),
    .c0_upd_target(c0_upd_target),
    .c0_upd_taken (c0_upd_taken),
    .c1_upd_valid (c1_upd_valid),
    .c1_upd_ready (c1_upd_ready),
    .c1_upd_pc    (c1_upd_pc),
    .c1_upd_target(c1_upd_target),
    .c1_upd_taken (c1_upd_taken),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .tbl_wr_en    (tbl_wr_en),
    .tbl_wr_clear (tbl_wr_clear),
    .tbl_wr_idx   (tbl_wr_idx),
    .tbl_wr_pc    (tbl_wr_pc),
    .tbl_wr_target(tbl_wr_target),
    .tbl_wr_taken (tbl_wr_taken),
    .tbl_wr_src   (tbl_wr_src)
`ifdef BP_ARB_STATS_EN
    ,
    .c0_stall_cnt (c0_stall_cnt),
    .c1_stall_cnt (c1_stall_cnt)
`endif
  );

`ifndef BP_ARB_STATS_EN
  assign c0_stall_cnt = '0;
  assign c1_stall_cnt = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    bit             en;
    bit             clr;
    bit [IDX_W-1:0] idx;
    bit             src;
    bit             tk;
    bit [31:0]      pc;
    bit [31:0]      tgt;
    bit             busy;
    bit             r0;
    bit             r1;
    bit [15:0]      s0;
    bit [15:0]      s1;
  } exp_t;

  typedef struct {
    bit [31:0] pc;
    bit [31:0] tgt;
    bit        tk;
  } ent_t;

  exp_t expq[$];
  ent_t fq0[$];
  ent_t fq1[$];
  exp_t last;
  int   sweep_left;
  int   sweep_idx;
  bit   last_gnt;
  bit [15:0] ms0;
  bit [15:0] ms1;
  bit   acc0;
  bit   acc1;

  int   vectors = 0;
  int   miscompares = 0;

  int   p0 = 0;
  int   p1 = 0;
  int   left0 = 0;
  int   left1 = 0;
  int   pclr = 0;
  bit   force_clr = 0;

  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq0.delete();
    fq1.delete();
    expq.delete();
    sweep_left = NIDX;
    sweep_idx  = 0;
    last_gnt   = 1'b1;
    ms0 = '0;
    ms1 = '0;
    acc0 = 0;
    acc1 = 0;
    last = '{default: 0};
  endtask

  // One clock edge of the reference behaviour, from the sampled inputs.
  task automatic model_step();
    exp_t e;
    ent_t t;
    bit   g;
    e = last;
    e.en  = 0;
    e.clr = 0;
    acc0 = c0_upd_valid && fq0.size() < DEPTH;
    acc1 = c1_upd_valid && fq1.size() < DEPTH;
    if (c0_upd_valid && !acc0 && ms0 != 16'hFFFF) ms0++;
    if (c1_upd_valid && !acc1 && ms1 != 16'hFFFF) ms1++;
    if (sweep_left > 0) begin
      e.en  = 1;
      e.clr = 1;
      e.idx = IDX_W'(sweep_idx);
      e.pc  = 0;
      e.tgt = 0;
      e.tk  = 0;
      e.src = 0;
      sweep_idx = (sweep_idx + 1) % NIDX;
      sweep_left--;
    end else begin
      if (fq0.size() + fq1.size() > 0) begin
        if (fq0.size() > 0 && fq1.size() > 0) g = !last_gnt;
        else g = fq1.size() > 0;
        t = g ? fq1.pop_front() : fq0.pop_front();
        e.en  = 1;
        e.idx = IDX_W'(t.pc % NIDX);
        e.pc  = t.pc;
        e.tgt = t.tgt;
        e.tk  = t.tk;
        e.src = g;
        last_gnt = g;
      end
      if (clear_req) begin
        sweep_left = NIDX;
        sweep_idx  = 0;
        ms0 = 0;
        ms1 = 0;
      end
    end
    if (acc0) fq0.push_back('{c0_upd_pc, c0_upd_target, c0_upd_taken});
    if (acc1) fq1.push_back('{c1_upd_pc, c1_upd_target, c1_upd_taken});
    e.busy = (sweep_left > 0) || e.clr;
    e.r0 = fq0.size() < DEPTH;
    e.r1 = fq1.size() < DEPTH;
    e.s0 = ms0;
    e.s1 = ms1;
    last = e;
    expq.push_back(e);
  endtask

  function automatic logic [31:0] gen_pc();
    logic [31:0] pc;
    pc = $urandom;
    if ($urandom_range(3) == 0) pc[3:0] = 4'h5;
    return pc;
  endfunction

  task automatic drive_next();
    if (!c0_upd_valid || acc0) begin
      if (left0 > 0 && $urandom_range(99) < p0) begin
        c0_upd_valid  = 1;
        c0_upd_pc     = gen_pc();
        c0_upd_target = $urandom;
        c0_upd_taken  = 1'($urandom_range(1));
        left0--;
      end else begin
        c0_upd_valid = 0;
      end
    end
    if (!c1_upd_valid || acc1) begin
      if (left1 > 0 && $urandom_range(99) < p1) begin
        c1_upd_valid  = 1;
        c1_upd_pc     = gen_pc();
        c1_upd_target = $urandom;
        c1_upd_taken  = 1'($urandom_range(1));
        left1--;
      end else begin
        c1_upd_valid = 0;
      end
    end
    clear_req = force_clr || ($urandom_range(999) < pclr);
    force_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    else begin
      acc0 = 0;
      acc1 = 0;
    end
    #1;
    drive_next();
  endtask

  task automatic check_reset_vals();
    chk("rst_write",
        {tbl_wr_en, tbl_wr_clear, tbl_wr_idx, tbl_wr_src, tbl_wr_taken,
         tbl_wr_pc, tbl_wr_target}, '0);
    chk("rst_busy", clear_busy, 1);
    chk("rst_ready", {c1_upd_ready, c0_upd_ready}, 2'b11);
`ifdef BP_ARB_STATS_EN
    chk("rst_stall", {c1_stall_cnt, c0_stall_cnt}, '0);
`endif
  endtask

  task automatic do_reset();
    reset_n = 0;
    c0_upd_valid = 0;
    c1_upd_valid = 0;
    clear_req = 0;
    model_reset();
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  function automatic bit model_idle();
    return sweep_left == 0 && fq0.size() == 0 && fq1.size() == 0 &&
           !c0_upd_valid && !c1_upd_valid;
  endfunction

  task automatic wait_idle(string nm, int lim);
    int n = 0;
    while (!model_idle() && n < lim) begin
      tick();
      n++;
    end
    chk(nm, model_idle(), 1);
  endtask

  // Monitor: compares every visible cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("write",
              {tbl_wr_en, tbl_wr_clear, tbl_wr_idx, tbl_wr_src, tbl_wr_taken,
               tbl_wr_pc, tbl_wr_target},
              {e.en, e.clr, e.idx, e.src, e.tk, e.pc, e.tgt});
          chk("busy", clear_busy, e.busy);
          chk("ready", {c1_upd_ready, c0_upd_ready}, {e.r1, e.r0});
`ifdef BP_ARB_STATS_EN
          chk("stall", {c1_stall_cnt, c0_stall_cnt}, {e.s1, e.s0});
`endif
        end else begin
          chk("unexp_write", tbl_wr_en, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();

    // Core 1 streams 6 updates while INIT sweeps.
    p1 = 100;
    left1 = 6;
    drive_next();
    wait_idle("init_stream_idle", 80);

    // Both cores push 3 back-to-back.
    p0 = 100;
    p1 = 100;
    left0 = 3;
    left1 = 3;
    drive_next();
    wait_idle("alt_idle", 40);

    // Single directed update on core 0.
    tick();
    c0_upd_valid  = 1;
    c0_upd_pc     = 32'h0000_0108;
    c0_upd_target = 32'h0000_0200;
    c0_upd_taken  = 1;
    tick();
    wait_idle("directed_idle", 20);

    // Clear while entries are queued, then a mid-sweep clear pulse.
    left0 = 4;
    left1 = 4;
    drive_next();
    repeat (3) tick();
    force_clr = 1;
    tick();
    repeat (6) tick();
    force_clr = 1;
    tick();
    wait_idle("clear_idle", 80);

    // Reset mid-CLEAR once idx 7 has been written.
    force_clr = 1;
    tick();
    n = 0;
    while (!(last.clr && last.idx == 7) && n < 40) begin
      tick();
      n++;
    end
    chk("reach_idx7", {last.clr, last.idx}, {1'b1, 4'd7});
    @(negedge clk);
    #1;
    do_reset();
    drive_next();
    wait_idle("post_reset_idle", 60);

    // Randomized traffic with occasional clears.
    p0 = 55;
    p1 = 55;
    left0 = 1000000;
    left1 = 1000000;
    pclr = 8;
    repeat (600) tick();
    p0 = 0;
    p1 = 0;
    pclr = 0;
    wait_idle("final_idle", 200);
    repeat (3) tick();
    @(negedge clk);
    #1;
    chk("scoreboard_empty", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_update_arbiter.md
Name: bp_update_arbiter

Overview:
- Shares the single update port of the correlated branch predictor/BTB between the branch stages of core 0 and core 1.
- Each core has its own small FIFO of resolved-branch updates. A round-robin arbiter drains at most one update per cycle into the predictor table write port.
- A sweep sequencer clears all table indices after reset and whenever software or pipeline control requests a clear. The block sits between the per-core branch stages and the shared predictor tables.

Parameters:
- DEPTH, 4, entries per per-core update FIFO (power of 2, ≥2)
- IDX_W, 12, table index width; the sweep covers 2**IDX_W entries
- PC_W, 32, PC/target width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- c0_upd_valid  in  1  core 0 update valid
- c0_upd_ready  out  1  core 0 FIFO can accept
- c0_upd_pc  in  PC_W  core 0 branch PC
- c0_upd_target  in  PC_W  core 0 resolved next PC
- c0_upd_taken  in  1  core 0 actual direction
- c1_upd_valid / c1_upd_ready / c1_upd_pc / c1_upd_target / c1_upd_taken  same widths, core 1
- clear_req  in  1  single-cycle request to clear all tables
- clear_busy  out  1  high while a sweep is running (INIT or CLEAR)
- tbl_wr_en  out  1  registered table write strobe
- tbl_wr_clear  out  1  write is a reset-value clear (BHT=01, history=0, BTB invalid)
- tbl_wr_idx  out  IDX_W  table index: pc[IDX_W-1:0] for updates, sweep counter for clears
- tbl_wr_pc  out  PC_W  branch PC (0 on clear)
- tbl_wr_target  out  PC_W  target (0 on clear)
- tbl_wr_taken  out  1  direction (0 on clear)
- tbl_wr_src  out  1  granted core for the update (0 on clear)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=INIT, sweep counter=0, both FIFOs empty, round-robin pointer=core 0.
  - All tbl_* outputs 0; clear_busy=1; both ready=1.
- FSM states: INIT, RUN, CLEAR.
  - INIT/CLEAR: each cycle, register a clear write (tbl_wr_en=1, tbl_wr_clear=1, idx=counter), then increment the counter.
  - After writing idx 2**IDX_W-1, the counter wraps to 0 and the state goes to RUN. A full sweep takes exactly 2**IDX_W cycles.
  - RUN and clear_req=1 → CLEAR next cycle. The update granted in that cycle, if any, is still written.
  - clear_req during INIT or CLEAR is ignored; the sweep is not restarted.
- FIFOs:
  - cN_upd_ready = (count<DEPTH), taken from registered state only.
  - Push on valid&&ready. Push and pop in the same cycle leaves the count unchanged.
  - Pushes are accepted in every state. Pops occur only in RUN.
  - Entries queued before or during a CLEAR are retained and drained after it; they are not discarded.
  - Order within each core is strictly FIFO.
- Arbitration (RUN only):
  - Only core X's FIFO non-empty → grant X.
  - Both non-empty → grant the core not granted last. The pointer updates only on a grant.
  - Neither non-empty → tbl_wr_en=0.
- Latency:
  - An update sampled at edge E sits in the FIFO after E. If granted in the next cycle, tbl_wr_en is high in the cycle after edge E+1: minimum 2 cycles, no bypass path.
- Outputs:
  - All tbl_* outputs are registered.
  - tbl_wr_en is a single-cycle strobe per write. Data fields hold their last value when tbl_wr_en=0.
- Same-index updates from both cores: no merging. They are written on consecutive grants, in arbitration order.
- Reset asserted mid-sweep or mid-drain: immediate return to reset values. Queued updates are lost and INIT restarts from idx 0.
- Throughput: one table write per cycle. The sustained rate per core when both cores stream is 1/2.

Optional Feature:
- Macro BP_ARB_STATS_EN.
- Defined:
  - Adds outputs c0_stall_cnt and c1_stall_cnt, 16 bits each.
  - Each counts cycles with cN_upd_valid=1 && cN_upd_ready=0, saturating at 16'hFFFF.
  - Both are zeroed by reset and by a clear_req that is accepted (RUN state).
- Not defined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release with IDX_W=4 → exactly 16 clear writes, idx 0..15 in order, clear_busy high for those 16 cycles, then RUN with tbl_wr_en=0.
- RUN, core 0 pushes pc=0x0000_0108, target=0x0000_0200, taken=1 at edge E → tbl_wr_en=1 after E+1 with idx=0x108, src=0, taken=1, target=0x200.
- Both cores push 3 updates each in back-to-back cycles → writes alternate src 0,1,0,1,0,1, starting with core 0 after reset, each core's entries in push order.
- Core 1 streams 6 updates during INIT with DEPTH=4 → ready drops after the 4th accept. With BP_ARB_STATS_EN, c1_stall_cnt increments per stalled cycle. After INIT, the 4 entries drain, then the remaining 2 are accepted.
- clear_req in RUN while core 0 holds 2 entries → the current grant completes, a sweep of 2**IDX_W clears follows, then the 2 remaining updates are written. A clear_req pulsed mid-sweep causes no restart.
- reset_n dropped mid-CLEAR at sweep idx 7 → outputs 0 immediately, FIFOs empty, and after release INIT restarts at idx 0.
